mux4_scan_ctrl: RTL

// - Upstream sequencer for the 4:1 bit mux (x0..x3, s[1:0] -> y). Drives s, walks channels 0..3,

---
 rtl/mux4_scan_pkg.sv | 13 +
 rtl/mux4_dwell_timer.sv | 36 +++
 rtl/mux4to1.sv | 21 ++
 rtl/mux4_scan_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/mux4_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
// No logic; pure type/constant definitions.
// No flow control.
package mux4_scan_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } scan_state_t;
endpackage

// File: rtl/mux4_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled, wraps to 0, flags the last cycle.
// Latency: done is combinational from the count register and en.
// No backpressure; clr has priority over en.
module mux4_dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear, or advance and wrap at the end of the dwell window.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign done = (cnt_q == LAST) && en;
endmodule

// File: rtl/mux4to1.sv
// 4:1 single-bit multiplexer driven by the scan controller's select.
// Latency: combinational.
// No backpressure.
module mux4to1 (
    input  logic       x0,
    input  logic       x1,
    input  logic       x2,
    input  logic       x3,
    input  logic [1:0] s,
    output logic       y
);
    // Select one of the four inputs.
    always_comb begin
        case (s)
            2'd0:    y = x0;
            2'd1:    y = x1;
            2'd2:    y = x2;
            default: y = x3;
        endcase
    end
endmodule

// File: rtl/mux4_scan_ctrl.sv
// Walks the mux select over channels 0..3, samples y at the end of each dwell, emits a 4-bit frame.
// Latency: frame_valid rises 4*DWELL cycles after start is accepted; 4*DWELL+1 per frame when continuous.
// Backpressure: frame is held in HOLD (select parked on channel 3) until frame_ready.
module mux4_scan_ctrl
    import mux4_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       abort,
    output logic [1:0] s,
    input  logic       y,
    output logic [3:0] frame_data,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy
);
    scan_state_t state_q, state_d;
    logic [SEL_W-1:0]  s_q, s_d;
    logic [NUM_CH-2:0] sample_q, sample_d;
    logic [NUM_CH-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    logic tmr_clr, tmr_en, tmr_done;
    logic last_ch, handoff;

    mux4_dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .done (tmr_done)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = SCAN;
                SCAN:    if (tmr_done && last_ch) state_d = HOLD;
                HOLD:    if (valid_q && frame_ready) state_d = cont ? SCAN : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: timer control and the frame handoff strobe.
    always_comb begin
        tmr_en  = (state_q == SCAN) && !abort;
        tmr_clr = (state_q != SCAN) || abort;
        last_ch = (s_q == SEL_W'(NUM_CH - 1));
        handoff = (state_q == HOLD) && valid_q && frame_ready && !abort;
        busy    = (state_q != IDLE);
    end

    // Datapath next values: select, partial samples, frame and valid.
    always_comb begin
        s_d      = s_q;
        sample_d = sample_q;
        data_d   = data_q;
        valid_d  = valid_q;
        if (abort) begin
            // Partial samples are dropped; the last delivered frame stays visible.
            s_d      = '0;
            sample_d = '0;
            valid_d  = 1'b0;
        end else begin
            if (tmr_done) begin
                if (!last_ch) begin
                    for (int i = 0; i < NUM_CH - 1; i++) begin
                        if (s_q == SEL_W'(i)) sample_d[i] = y;
                    end
                    s_d = s_q + 1'b1;
                end else begin
                    // Channel 3 goes straight into the frame, no sample slot needed.
                    data_d  = {y, sample_q};
                    valid_d = 1'b1;
                end
            end
            if (handoff) begin
                valid_d = 1'b0;
                s_d     = '0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q      <= '0;
            sample_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            s_q      <= s_d;
            sample_q <= sample_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign s           = s_q;
    assign frame_data  = data_q;
    assign frame_valid = valid_q;
endmodule
